// File: rtl/uc_multiciclo.sv
// Multicycle RISC-V control unit: Moore FSM driving datapath enables
// and mux selects, with halt on unsupported opcode and a retire counter.
module uc_multiciclo #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  output logic                   wePC,
  output logic                   weIR,
  output logic                   weReg,
  output logic                   weMem,
  output logic                   sinalMux1,
  output logic [1:0]             sinalMux2,
  output logic                   sinalMux4,
  output logic [1:0]             aluop,
  output logic                   jump,
  output logic                   halted,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  state_t     st;
  logic [6:0] op_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= S_FETCH;
      op_q        <= '0;
      instr_count <= '0;
    end else begin
      // every state with wePC set retires exactly one instruction
      if (wePC)
        instr_count <= instr_count + COUNT_WIDTH'(1);
      unique case (st)
        S_FETCH:  st <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          case (opcode)
            OP_R:          st <= S_EXEC_R;
            OP_I:          st <= S_EXEC_I;
            OP_LD, OP_ST:  st <= S_MEM_ADDR;
            OP_BR:         st <= S_BRANCH;
            OP_JAL,
            OP_JALR:       st <= S_JUMP;
            default:       st <= S_HALT;
          endcase
        end
        S_EXEC_R,
        S_EXEC_I:   st <= S_WB_ALU;
        S_MEM_ADDR: st <= (op_q == OP_LD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   st <= S_WB_MEM;
        S_WB_ALU,
        S_WB_MEM,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP:     st <= S_FETCH;
        S_HALT:     st <= S_HALT;
        default:    st <= S_HALT;
      endcase
    end
  end

  always_comb begin
    wePC      = 1'b0;
    weIR      = 1'b0;
    weReg     = 1'b0;
    weMem     = 1'b0;
    sinalMux1 = 1'b0;
    sinalMux2 = 2'b00;
    sinalMux4 = 1'b0;
    aluop     = 2'b00;
    jump      = 1'b0;
    halted    = 1'b0;
    // enables drop the instant reset rises, before the state register reacts
    if (!reset) begin
      unique case (st)
        S_FETCH:  weIR = 1'b1;
        S_DECODE: ;
        S_EXEC_R: aluop = 2'b10;
        S_EXEC_I: begin
          aluop     = 2'b10;
          sinalMux1 = 1'b1;
        end
        S_WB_ALU: begin
          aluop     = 2'b10;
          sinalMux1 = (op_q == OP_I);
          weReg     = 1'b1;
          sinalMux2 = 2'b01;
          wePC      = 1'b1;
        end
        S_MEM_ADDR,
        S_MEM_RD: sinalMux1 = 1'b1;
        S_WB_MEM: begin
          sinalMux1 = 1'b1;
          weReg     = 1'b1;
          wePC      = 1'b1;
        end
        S_MEM_WR: begin
          sinalMux1 = 1'b1;
          weMem     = 1'b1;
          wePC      = 1'b1;
        end
        S_BRANCH: begin
          aluop = 2'b01;
          wePC  = 1'b1;
        end
        S_JUMP: begin
          jump      = 1'b1;
          wePC      = 1'b1;
          weReg     = 1'b1;
          sinalMux2 = 2'b10;
          sinalMux1 = 1'b1;
          sinalMux4 = (op_q == OP_JALR);
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = st;

endmodule
